// File: rtl/contador_entradas_multi_if.sv
// Entry-path bundle between the button/field-select front end and the counter bank.
// master drives selection, load and buttons; slave returns channel values and the step strobe.
interface contador_entradas_multi_if #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 3
);
  localparam int CH_W = $clog2(CHANNELS);

  logic [CH_W-1:0]           ch_sel;
  logic                      Num_Ld;
  logic [WIDTH-1:0]          Ld_bin;
  logic                      PB_up;
  logic                      PB_down;
  logic [CHANNELS*WIDTH-1:0] Cont_max;
  logic [CHANNELS*WIDTH-1:0] Wr_bin;
  logic [WIDTH-1:0]          sel_bin;
  logic                      step;

  modport master (
    output ch_sel, Num_Ld, Ld_bin, PB_up, PB_down, Cont_max,
    input  Wr_bin, sel_bin, step
  );

  modport slave (
    input  ch_sel, Num_Ld, Ld_bin, PB_up, PB_down, Cont_max,
    output Wr_bin, sel_bin, step
  );
endinterface

// File: rtl/contador_entradas_multi.sv
// Multi-channel up/down setting counter driven by pushbuttons with press-edge stepping,
// hold-to-repeat, per-channel wrap/saturate limits and a parallel load path.
module contador_entradas_multi #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 3,
  parameter int HOLD_DLY = 25_000_000,
  parameter int RPT_PER  = 10_000_000,
  parameter bit WRAP     = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  contador_entradas_multi_if.slave bus
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_DLY - 1);
  localparam logic [31:0] RPT_LAST  = 32'(RPT_PER - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RPT} state_t;

  state_t           state, state_nxt;
  logic [31:0]      timer, timer_nxt;
  logic             dir_up, dir_up_nxt;
  logic             up_q, dn_q, armed;
  logic             only_up, only_dn, up_edge, dn_edge, held;
  logic             step_evt, step_q;
  logic [WIDTH-1:0] ch_val [CHANNELS];
  logic             sel_ok, wr_en;
  logic [WIDTH-1:0] sel_val, sel_max, ld_val, stepped, wr_data;

  // armed stays low after reset until both buttons are seen released, so a
  // button held through reset cannot masquerade as a fresh press.
  assign only_up = bus.PB_up & ~bus.PB_down;
  assign only_dn = bus.PB_down & ~bus.PB_up;
  assign up_edge = armed & only_up & ~up_q;
  assign dn_edge = armed & only_dn & ~dn_q;
  assign held    = dir_up ? only_up : only_dn;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    dir_up_nxt = dir_up;
    step_evt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (up_edge || dn_edge) begin
          step_evt   = 1'b1;
          dir_up_nxt = up_edge;
          timer_nxt  = '0;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!held) begin
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (timer == HOLD_LAST) begin
          step_evt  = 1'b1;
          timer_nxt = '0;
          state_nxt = ST_RPT;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      ST_RPT: begin
        if (!held) begin
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (timer == RPT_LAST) begin
          step_evt  = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_ok  = 1'b0;
    sel_val = '0;
    sel_max = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(bus.ch_sel) == 32'(k)) begin
        sel_ok  = 1'b1;
        sel_val = ch_val[k];
        sel_max = bus.Cont_max[k*WIDTH +: WIDTH];
      end
    end
  end

  // Values left above a lowered max snap to the max on the next down step.
  always_comb begin
    ld_val = (bus.Ld_bin > sel_max) ? sel_max : bus.Ld_bin;
    if (dir_up_nxt) begin
      stepped = (sel_val >= sel_max) ? (WRAP ? '0 : sel_max) : sel_val + WIDTH'(1);
    end else if (sel_val == '0) begin
      stepped = WRAP ? sel_max : '0;
    end else if (sel_val > sel_max) begin
      stepped = sel_max;
    end else begin
      stepped = sel_val - WIDTH'(1);
    end
    wr_en   = sel_ok & (bus.Num_Ld | step_evt);
    wr_data = bus.Num_Ld ? ld_val : stepped;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      timer  <= '0;
      dir_up <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      armed  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      dir_up <= dir_up_nxt;
      up_q   <= bus.PB_up;
      dn_q   <= bus.PB_down;
      armed  <= armed | (~bus.PB_up & ~bus.PB_down);
      step_q <= step_evt & sel_ok & ~bus.Num_Ld;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHANNELS; k++) ch_val[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_en && 32'(bus.ch_sel) == 32'(k)) ch_val[k] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_wr
    assign bus.Wr_bin[g*WIDTH +: WIDTH] = ch_val[g];
  end

  assign bus.sel_bin = sel_val;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_contador_entradas_multi.sv
// Directed bench for contador_entradas_multi: expected step pulses are queued with their
// due cycle and channel snapshot, and a monitor pops them whenever step is seen.
module tb_contador_entradas_multi;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  typedef struct {
    int          due;
    logic [31:0] wr;
  } exp_t;

  exp_t sb_q[$];

  contador_entradas_multi_if #(.WIDTH(7), .CHANNELS(3)) bus ();
  contador_entradas_multi_if #(.WIDTH(7), .CHANNELS(3)) bus_s ();

  contador_entradas_multi #(
    .WIDTH(7), .CHANNELS(3), .HOLD_DLY(4), .RPT_PER(2), .WRAP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Saturating build shares all inputs with the main instance.
  contador_entradas_multi #(
    .WIDTH(7), .CHANNELS(3), .HOLD_DLY(4), .RPT_PER(2), .WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  assign bus_s.ch_sel   = bus.ch_sel;
  assign bus_s.Num_Ld   = bus.Num_Ld;
  assign bus_s.Ld_bin   = bus.Ld_bin;
  assign bus_s.PB_up    = bus.PB_up;
  assign bus_s.PB_down  = bus.PB_down;
  assign bus_s.Cont_max = bus.Cont_max;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pack(input logic [6:0] c0, input logic [6:0] c1,
                                       input logic [6:0] c2);
    return {11'd0, c2, c1, c0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int due, input logic [31:0] wr);
    sb_q.push_back('{due: due, wr: wr});
  endtask

  task automatic applyStimulus(input logic up, input logic dn, input logic ld,
                               input logic [6:0] ldv, input logic [1:0] sel, input int n);
    bus.PB_up   = up;
    bus.PB_down = dn;
    bus.Num_Ld  = ld;
    bus.Ld_bin  = ldv;
    bus.ch_sel  = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic up, input logic [1:0] sel, input logic exp_step,
                     input logic [31:0] exp_wr);
    if (exp_step) push_exp(cyc + 1, exp_wr);
    applyStimulus(up, ~up, 1'b0, 7'd0, sel, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, sel, 2);
  endtask

  always @(negedge clk) begin
    if (reset && bus.step === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_step: step=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("step_cycle", 32'(cyc), 32'(e.due));
        checkOutput("step_wr", 32'(bus.Wr_bin), e.wr);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    bus.ch_sel   = 2'd0;
    bus.Num_Ld   = 1'b0;
    bus.Ld_bin   = 7'd0;
    bus.PB_up    = 1'b0;
    bus.PB_down  = 1'b0;
    bus.Cont_max = 21'(pack(7'd100, 7'd59, 7'd23));
    repeat (2) @(negedge clk);
    checkOutput("rst_wr", 32'(bus.Wr_bin), 32'd0);
    checkOutput("rst_step", 32'(bus.step), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 2);

    // Loads, then async reset asserted while a step pulse is showing.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd10, 2'd0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd20, 2'd1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd1, 1);
    checkOutput("load_wr", 32'(bus.Wr_bin), pack(7'd10, 7'd20, 7'd0));
    push_exp(cyc + 1, pack(7'd10, 7'd21, 7'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd1, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_wr", 32'(bus.Wr_bin), 32'd0);
    checkOutput("async_rst_step", 32'(bus.step), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 1);
    push_exp(cyc + 1, pack(7'd1, 7'd0, 7'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 2);
    checkOutput("post_rst_wr", 32'(bus.Wr_bin), pack(7'd1, 7'd0, 7'd0));
    checkOutput("drain_a", 32'(sb_q.size()), 32'd0);

    // Wrap at max and at zero; the saturating copy holds its limits.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd59, 2'd1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd1, 1);
    checkOutput("load59_wr", 32'(bus.Wr_bin), pack(7'd1, 7'd59, 7'd0));
    tap(1'b1, 2'd1, 1'b1, pack(7'd1, 7'd0, 7'd0));
    tap(1'b0, 2'd1, 1'b1, pack(7'd1, 7'd59, 7'd0));
    tap(1'b0, 2'd2, 1'b1, pack(7'd1, 7'd59, 7'd23));
    checkOutput("sat_wr", 32'(bus_s.Wr_bin), pack(7'd1, 7'd58, 7'd0));

    // Hold for 12 cycles: press, press+4, then every 2.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 2'd0, 1);
    t = cyc;
    push_exp(t + 1,  pack(7'd1, 7'd59, 7'd23));
    push_exp(t + 5,  pack(7'd2, 7'd59, 7'd23));
    push_exp(t + 7,  pack(7'd3, 7'd59, 7'd23));
    push_exp(t + 9,  pack(7'd4, 7'd59, 7'd23));
    push_exp(t + 11, pack(7'd5, 7'd59, 7'd23));
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 12);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 3);
    checkOutput("hold_wr", 32'(bus.Wr_bin), pack(7'd5, 7'd59, 7'd23));
    checkOutput("drain_b", 32'(sb_q.size()), 32'd0);

    // Load clamping, load beating a press edge, and an unclamped lowered max.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd10, 2'd2, 1);
    checkOutput("load10_wr", 32'(bus.Wr_bin), pack(7'd5, 7'd59, 7'd10));
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd100, 2'd2, 1);
    checkOutput("load_clamp_wr", 32'(bus.Wr_bin), pack(7'd5, 7'd59, 7'd23));
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd5, 2'd2, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 2);
    checkOutput("load_wins_wr", 32'(bus.Wr_bin), pack(7'd5, 7'd59, 7'd5));
    bus.Cont_max = 21'(pack(7'd3, 7'd59, 7'd23));
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 1);
    checkOutput("no_clamp_sel", 32'(bus.sel_bin), 32'd5);
    tap(1'b0, 2'd0, 1'b1, pack(7'd3, 7'd59, 7'd5));
    bus.Cont_max = 21'(pack(7'd100, 7'd59, 7'd23));

    // Both buttons together, then the survivor needs a fresh press.
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd0, 2'd1, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd1, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd1, 1);
    checkOutput("both_wr", 32'(bus.Wr_bin), pack(7'd3, 7'd59, 7'd5));
    tap(1'b1, 2'd1, 1'b1, pack(7'd3, 7'd0, 7'd5));

    // Retarget during repeat: later steps land in ch2.
    t = cyc;
    push_exp(t + 1,  pack(7'd4, 7'd0, 7'd5));
    push_exp(t + 5,  pack(7'd5, 7'd0, 7'd5));
    push_exp(t + 7,  pack(7'd6, 7'd0, 7'd5));
    push_exp(t + 9,  pack(7'd6, 7'd0, 7'd6));
    push_exp(t + 11, pack(7'd6, 7'd0, 7'd7));
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd2, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 3);
    checkOutput("retarget_wr", 32'(bus.Wr_bin), pack(7'd6, 7'd0, 7'd7));
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 1);
    checkOutput("sel_bin0", 32'(bus.sel_bin), 32'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 1);
    checkOutput("sel_bin2", 32'(bus.sel_bin), 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd3, 1);
    checkOutput("sel_bin3", 32'(bus.sel_bin), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd50, 2'd3, 1);
    tap(1'b1, 2'd3, 1'b0, 32'd0);
    checkOutput("sel3_wr", 32'(bus.Wr_bin), pack(7'd6, 7'd0, 7'd7));

    // Zero max pins the channel; full-range max wraps cleanly.
    bus.Cont_max = 21'(pack(7'd100, 7'd0, 7'd23));
    tap(1'b1, 2'd1, 1'b1, pack(7'd6, 7'd0, 7'd7));
    bus.Cont_max = 21'(pack(7'd100, 7'd0, 7'd127));
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd127, 2'd2, 1);
    tap(1'b1, 2'd2, 1'b1, pack(7'd6, 7'd0, 7'd0));
    tap(1'b0, 2'd2, 1'b1, pack(7'd6, 7'd0, 7'd127));
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd2, 2);
    checkOutput("final_wr", 32'(bus.Wr_bin), pack(7'd6, 7'd0, 7'd127));
    checkOutput("final_step", 32'(bus.step), 32'd0);
    checkOutput("drain_end", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
